// File: rtl/operand_arbiter.sv
// operand_arbiter
//   Four-way round-robin arbiter feeding a single registered operand word to
//   the ALU operand stage.  A requester's word is captured only in the cycle
//   its req_ready bit is high; the captured word is held on out_data/out_src
//   until the consumer accepts it with out_ready.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word held, out_valid=0, out_ready ignored
//   HOLD  | word held on out_data/out_src, out_valid=1
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester offer
//   req_data   requester i word in bits [i*W +: W]
//   req_ready  one-hot (or zero) accept strobe, combinational
//   out_valid  out_data/out_src hold a granted word
//   out_ready  consumer accepts the held word
//   out_data   registered granted word
//   out_src    registered index of the winning requester
//   xfer_cnt   completed output handshakes, wraps 255 -> 0
module operand_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  input  logic [4*W-1:0] req_data,
  output logic [3:0]     req_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_src,
  output logic [7:0]     xfer_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state;
  logic [1:0] rr_ptr;
  logic       grant_opp;
  logic       grant;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // A new word may be loaded when nothing is held, or when the held word
  // leaves this cycle.
  assign grant_opp = (state == IDLE) || out_ready;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = '0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Gated by rst so no requester sees an accept while reset is applied.
  assign grant     = grant_opp && win_found && !rst;
  assign req_ready = grant ? (4'b0001 << win_idx) : 4'b0000;
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      out_data <= '0;
      out_src  <= 2'd0;
      xfer_cnt <= 8'd0;
    end else begin
      if (out_valid && out_ready) begin
        xfer_cnt <= xfer_cnt + 8'd1;
      end
      if (grant) begin
        out_data <= req_data[int'(win_idx)*W +: W];
        out_src  <= win_idx;
        rr_ptr   <= win_idx + 2'd1;
        state    <= HOLD;
      end else if ((state == HOLD) && out_ready) begin
        // Drained with nobody waiting; out_data/out_src keep last values.
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_operand_arbiter.sv
// tb_operand_arbiter
//   Scoreboard bench for operand_arbiter.  The stimulus side predicts each
//   grant from a plain round-robin model and pushes the expected word; the
//   monitor compares whatever the DUT presents against the queue head.
module tb_operand_arbiter;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   src;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic [7:0]     xfer_cnt;

  operand_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .xfer_cnt  (xfer_cnt)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // reference model state
  int         m_ptr  = 0;
  bit         m_hold = 0;
  int         last_win = -1;
  logic [7:0] m_cnt  = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; predicts the accept and the word to be loaded.
  task automatic step(input logic [3:0] vm, input logic [4*W-1:0] d, input logic ordy);
    logic [3:0] exp_ready;
    exp_t       e;
    int         idx;
    @(posedge clk);
    #1;
    req_valid = vm;
    req_data  = d;
    out_ready = ordy;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    last_win  = -1;
    exp_ready = 4'b0000;
    if (!m_hold || ordy) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (last_win < 0 && vm[idx]) last_win = idx;
      end
    end
    if (last_win >= 0) exp_ready[last_win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (last_win >= 0) begin
      e.data = d[last_win*W +: W];
      e.src  = 2'(last_win);
      sb.push_back(e);
      m_ptr  = (last_win + 1) % 4;
      m_hold = 1'b1;
    end else if (m_hold && ordy) begin
      m_hold = 1'b0;
    end
  endtask

  // Asserts reset between edges and checks the outputs clear with no clock.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_src",   32'(out_src),   32'd0);
    chk("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    m_ptr  = 0;
    m_hold = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares the presented word each cycle, retires it on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        m_cnt = 8'd0;
      end else begin
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
          end else begin
            e = sb[0];
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_src",  32'(out_src),  32'(e.src));
            if (out_ready) begin
              void'(sb.pop_front());
              m_cnt = m_cnt + 8'd1;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [3:0]     pend;
    logic [W-1:0]   wd [4];
    logic [4*W-1:0] d;

    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = '0;
    out_ready = 1'b0;
    do_reset();

    // single requester 2
    d = '0;
    d[2*W +: W] = 8'h3C;
    step(4'b0100, d, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("single_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // round robin from reset, all requesting
    do_reset();
    d = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++) step(4'b1111, d, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);

    // backpressure, then resume
    step(4'b0001, {8'h0, 8'h0, 8'h0, 8'hA1}, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0011, {8'h0, 8'h0, 8'hB2, 8'hB1}, 1'b0);
    step(4'b0011, {8'h0, 8'h0, 8'hB2, 8'hB1}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);

    // counter wrap: 257 grants yield 256 handshakes
    do_reset();
    for (int i = 0; i < 257; i++) step(4'b0001, {24'h0, 8'(i)}, 1'b1);
    chk("cnt_255", 32'(xfer_cnt), 32'd255);
    step(4'b0000, '0, 1'b0);
    chk("cnt_wrap0", 32'(xfer_cnt), 32'd0);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);

    // randomized traffic with drops and backpressure
    pend = 4'b0000;
    for (int i = 0; i < 4; i++) wd[i] = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && $urandom_range(15) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          wd[i]   = W'($urandom);
        end
      end
      for (int i = 0; i < 4; i++) d[i*W +: W] = wd[i];
      step(pend, d, ($urandom_range(3) != 0));
      if (last_win >= 0) pend[last_win] = 1'b0;
    end
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("drained_idle", 32'(out_valid), 32'd0);

    // reset mid-HOLD discards the held word
    step(4'b0001, {24'h0, 8'h5A}, 1'b0);
    step(4'b0000, '0, 1'b0);
    chk("hold_5a", 32'(out_data), 32'h5A);
    do_reset();
    step(4'b0000, '0, 1'b1);
    chk("post_rst_cnt", 32'(xfer_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_arbiter.md
OPERAND_ARBITER -- requirements
Module: operand_arbiter

Interface
REQ-001 Parameter W, default 8, data width of each requester word and of the output word.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  4  bit i high: requester i offers req_data word i.
REQ-005 req_data  input  4*W  requester i word in bits [i*W +: W].
REQ-006 req_ready  output  4  bit i high: requester i word accepted this cycle; at most one bit high.
REQ-007 out_valid  output  1  out_data/out_src hold a granted word.
REQ-008 out_ready  input  1  consumer (ALU operand stage) accepts the output word.
REQ-009 out_data  output  W  registered granted word.
REQ-010 out_src  output  2  registered index of the requester that supplied out_data; drives the downstream 4:1 select.
REQ-011 xfer_cnt  output  8  count of completed output handshakes.

Function
REQ-012 The block SHALL implement two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 A grant opportunity SHALL exist in a cycle when state is IDLE, or when state is HOLD and out_ready=1.
REQ-014 On a grant opportunity with any req_valid bit set, the winner SHALL be the first set bit searched in order rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
REQ-015 The winner's req_ready bit SHALL be driven high combinationally in that cycle; all other req_ready bits SHALL be low.
REQ-016 req_ready SHALL be all zero when no grant opportunity exists or no req_valid bit is set.
REQ-017 On a grant, at the next edge: out_data <= winner word, out_src <= winner index, rr_ptr <= winner index + 1 (mod 4), state <= HOLD.
REQ-018 In HOLD with out_ready=0, out_data, out_src and out_valid SHALL hold stable, and rr_ptr SHALL not change.
REQ-019 In HOLD with out_ready=1 and no req_valid bit set, state SHALL go to IDLE at the next edge; out_data and out_src SHALL retain their last values.
REQ-020 In HOLD with out_ready=1 and a winner, state SHALL remain HOLD with the new word loaded (back-to-back, one word per cycle).
REQ-021 Latency: a word granted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1.
REQ-022 In IDLE, out_ready SHALL be ignored and xfer_cnt SHALL not change.
REQ-023 xfer_cnt SHALL increment by 1 on every cycle with out_valid=1 and out_ready=1, and SHALL wrap 255 -> 0.
REQ-024 rr_ptr SHALL be 2 bits and SHALL wrap 3 -> 0.
REQ-025 Requesters hold req_valid and req_data stable until their req_ready; the block SHALL capture data only in the req_ready cycle.
REQ-026 A requester deasserting req_valid before grant SHALL simply lose eligibility; no error is flagged.

Reset
REQ-027 While rst=1, regardless of clk: state=IDLE, out_valid=0, out_data=0, out_src=0, rr_ptr=0, xfer_cnt=0, req_ready=0.
REQ-028 rst asserted in HOLD SHALL discard the held word without a handshake and without incrementing xfer_cnt.
REQ-029 After rst deasserts, the first grant SHALL be evaluated at the first rising edge with rst=0.

Verification
REQ-030 Reset: drive rst=1 mid-HOLD with out_data=0x5A -> out_valid, out_data, out_src, xfer_cnt all 0 immediately, before the next clk edge.
REQ-031 Single requester: req_valid=0b0100, req_data word2=0x3C, out_ready=1 -> req_ready=0b0100 in cycle 0; cycle 1 out_valid=1, out_data=0x3C, out_src=2; xfer_cnt=1 after cycle 1.
REQ-032 Round robin: req_valid=0b1111 held, out_ready=1 from reset -> grant order 0,1,2,3,0 on consecutive cycles; out_src sequence 0,1,2,3,0.
REQ-033 Backpressure: one word in HOLD, out_ready=0 for 5 cycles with req_valid=0b0011 -> req_ready=0, out_data/out_src stable, rr_ptr unchanged; when out_ready=1, the next grant goes to the first requester at or after rr_ptr.
REQ-034 Counter wrap: 256 handshakes from reset -> xfer_cnt reads 255 after the 255th, 0 after the 256th.
REQ-035 Drain: HOLD, out_ready=1, req_valid=0 -> state IDLE and out_valid=0 next cycle; out_src retains its last value.
